// File: rtl/mips_pkg.sv
// mips_pkg: funct codes and controller state encoding shared by the multiply/divide unit.
package mips_pkg;
    localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
    localparam logic [5:0] FUNCT_MTHI  = 6'b010001;
    localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
    localparam logic [5:0] FUNCT_MTLO  = 6'b010011;
    localparam logic [5:0] FUNCT_MULT  = 6'b011000;
    localparam logic [5:0] FUNCT_MULTU = 6'b011001;
    localparam logic [5:0] FUNCT_DIV   = 6'b011010;
    localparam logic [5:0] FUNCT_DIVU  = 6'b011011;
    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} mdu_state_t;
endpackage

// File: rtl/mdu_divstep.sv
// mdu_divstep: one combinational restoring-division step on unsigned magnitudes.
module mdu_divstep #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic [WIDTH-1:0] i_quo,
    input  logic [WIDTH-1:0] i_div,
    output logic [WIDTH-1:0] o_rem,
    output logic [WIDTH-1:0] o_quo
);
    logic [WIDTH:0] w_shift, w_diff;
    assign w_shift = {i_rem, i_quo[WIDTH-1]};
    // The extra top bit of the difference is the borrow.
    assign w_diff = w_shift - {1'b0, i_div};
    assign o_rem  = w_diff[WIDTH] ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
    assign o_quo  = {i_quo[WIDTH-2:0], ~w_diff[WIDTH]};
endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: iterative MULT/DIV controller owning HI/LO, with MF*/MT* service and stall.
// Define MDU_DIV_EN to include DIV/DIVU; otherwise they are ignored like unknown functs.
module mdu_ctrl
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             md_valid,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    output logic             busy,
    output logic             stall,
    output logic [WIDTH-1:0] mdresult
);
    localparam int CW = $clog2(WIDTH);
    mdu_state_t         r_state;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH-1:0]   r_hi, r_lo, r_a;
    logic [2*WIDTH-1:0] r_acc;
    logic               r_neg_q;
    logic               w_signed;
    logic [WIDTH-1:0]   w_ma, w_mb;
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_prod, w_fix;
    assign w_signed = ~funct[0];
    assign w_ma     = (w_signed && srca[WIDTH-1]) ? -srca : srca;
    assign w_mb     = (w_signed && srcb[WIDTH-1]) ? -srcb : srcb;
    // Accumulator high half collects partial sums while the multiplier shifts out of the low half.
    assign w_sum    = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_a & {WIDTH{r_acc[0]}}};
    assign w_prod   = r_neg_q ? -r_acc : r_acc;
`ifdef MDU_DIV_EN
    logic             r_neg_r, r_is_div;
    logic [WIDTH-1:0] w_rem_n, w_quo_n;
    mdu_divstep #(.WIDTH(WIDTH)) u_divstep (
        .i_rem(r_acc[2*WIDTH-1:WIDTH]),
        .i_quo(r_acc[WIDTH-1:0]),
        .i_div(r_a),
        .o_rem(w_rem_n),
        .o_quo(w_quo_n)
    );
    assign w_fix = r_is_div ? {r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH],
                               r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0]} : w_prod;
`else
    assign w_fix = w_prod;
`endif
    assign busy     = r_state != IDLE;
    assign stall    = md_valid & busy;
    assign mdresult = !md_valid ? '0 : funct == FUNCT_MFHI ? r_hi : funct == FUNCT_MFLO ? r_lo : '0;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_a      <= '0;
            r_acc    <= '0;
            r_neg_q  <= 1'b0;
`ifdef MDU_DIV_EN
            r_neg_r  <= 1'b0;
            r_is_div <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: if (md_valid) begin
                    if (funct == FUNCT_MTHI) r_hi <= srca;
                    if (funct == FUNCT_MTLO) r_lo <= srca;
                    if (funct == FUNCT_MULT || funct == FUNCT_MULTU) begin
                        r_a     <= w_ma;
                        r_acc   <= {{WIDTH{1'b0}}, w_mb};
                        r_cnt   <= '0;
                        r_neg_q <= w_signed & (srca[WIDTH-1] ^ srcb[WIDTH-1]);
                        r_state <= MUL;
`ifdef MDU_DIV_EN
                        r_is_div <= 1'b0;
`endif
                    end
`ifdef MDU_DIV_EN
                    // Divide by zero skips iteration: FIX passes HI=srca, LO=all-ones through unsigned.
                    if (funct == FUNCT_DIV || funct == FUNCT_DIVU) begin
                        r_a      <= w_mb;
                        r_acc    <= (srcb == '0) ? {srca, {WIDTH{1'b1}}} : {{WIDTH{1'b0}}, w_ma};
                        r_cnt    <= '0;
                        r_is_div <= 1'b1;
                        r_neg_q  <= (srcb != '0) & w_signed & (srca[WIDTH-1] ^ srcb[WIDTH-1]);
                        r_neg_r  <= (srcb != '0) & w_signed & srca[WIDTH-1];
                        r_state  <= (srcb == '0) ? FIX : DIV;
                    end
`endif
                end
                MUL: begin
                    r_acc <= {w_sum, r_acc[WIDTH-1:1]};
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CW'(WIDTH-1)) r_state <= FIX;
                end
`ifdef MDU_DIV_EN
                DIV: begin
                    r_acc <= {w_rem_n, w_quo_n};
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CW'(WIDTH-1)) r_state <= FIX;
                end
`endif
                FIX: begin
                    {r_hi, r_lo} <= w_fix;
                    r_state      <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: directed and random checks of mdu_ctrl against an arithmetic HI/LO model.
module tb_mdu_ctrl;
    localparam int W = 32;
    localparam logic [5:0] F_MFHI = 6'b010000, F_MTHI = 6'b010001, F_MFLO = 6'b010010, F_MTLO = 6'b010011;
    localparam logic [5:0] F_MULT = 6'b011000, F_MULTU = 6'b011001, F_DIV = 6'b011010, F_DIVU = 6'b011011;
    logic clk = 1'b0, reset = 1'b0, md_valid = 1'b0;
    logic [5:0] funct = '0;
    logic [W-1:0] srca = '0, srcb = '0;
    logic busy, stall;
    logic [W-1:0] mdresult;
    int n_cmp = 0, n_bad = 0;
    logic [W-1:0] m_hi = '0, m_lo = '0;
    mdu_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .md_valid(md_valid), .funct(funct),
        .srca(srca), .srcb(srcb), .busy(busy), .stall(stall), .mdresult(mdresult)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    // Architectural result of one instruction: {HI, LO} after it, plus cycles busy stays high.
    task automatic model(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [63:0] res, output int lat);
        longint sa, sb;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        res = {m_hi, m_lo};
        lat = 0;
        if (f == F_MULT) begin res = 64'(sa * sb); lat = W + 1; end
        if (f == F_MULTU) begin res = {32'b0, a} * {32'b0, b}; lat = W + 1; end
        if (f == F_MTHI) res = {a, m_lo};
        if (f == F_MTLO) res = {m_hi, a};
`ifdef MDU_DIV_EN
        if ((f == F_DIV || f == F_DIVU) && b == 0) begin res = {a, 32'hFFFFFFFF}; lat = 1; end
        else if (f == F_DIV) begin res = {32'(sa % sb), 32'(sa / sb)}; lat = W + 1; end
        else if (f == F_DIVU) begin res = {a % b, a / b}; lat = W + 1; end
`endif
    endtask
    task automatic issue(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        md_valid = 1'b1; funct = f; srca = a; srcb = b;
        @(negedge clk);
        md_valid = 1'b0; funct = '0;
    endtask
    task automatic rd(input string tag);
        @(negedge clk);
        md_valid = 1'b1; funct = F_MFHI;
        #1 chk({tag, " stall"}, 64'(stall), 64'd0);
        chk({tag, " hi"}, 64'(mdresult), 64'(m_hi));
        funct = F_MFLO;
        #1 chk({tag, " lo"}, 64'(mdresult), 64'(m_lo));
        md_valid = 1'b0; funct = '0;
    endtask
    task automatic op(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
        logic [63:0] res;
        int lat, cnt;
        model(f, a, b, res, lat);
        issue(f, a, b);
        cnt = 0;
        while (busy && cnt < 100) begin cnt++; @(negedge clk); end
        chk({tag, " busy cycles"}, 64'(cnt), 64'(lat));
        {m_hi, m_lo} = res;
        rd(tag);
    endtask
    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFFFFFF;
            2: return 32'h80000000;
            3: return 32'($urandom_range(0, 20));
            default: return 32'($urandom);
        endcase
    endfunction
    initial begin
        logic [5:0] fl [8];
        logic [63:0] res;
        int lat, cnt;
        fl = '{F_MULT, F_MULTU, F_DIV, F_DIVU, F_MTHI, F_MTLO, 6'h20, 6'h2a};
        #12;
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset stall", 64'(stall), 64'd0);
        chk("reset mdresult", 64'(mdresult), 64'd0);
        @(negedge clk) reset = 1'b1;
        rd("after reset");
        op(F_MULT, 32'd7, 32'hFFFFFFFD, "mult 7*-3");
        op(F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, "multu max");
        op(F_DIV, 32'hFFFFFFF9, 32'd2, "div -7/2");
        op(F_DIV, 32'h80000000, 32'hFFFFFFFF, "div min/-1");
        op(F_DIVU, 32'h1234, 32'd0, "divu by 0");
        op(F_DIV, 32'h7, 32'hFFFFFFFE, "div 7/-2");
        @(negedge clk);
        md_valid = 1'b1; funct = F_MULT; srca = 32'd3; srcb = 32'd5;
        model(F_MULT, 32'd3, 32'd5, res, lat);
        @(negedge clk);
        funct = F_MFLO;
        cnt = 0;
        while (stall && cnt < 100) begin cnt++; @(negedge clk); end
        chk("mflo stall cycles", 64'(cnt), 64'(W + 1));
        chk("mflo after mult", 64'(mdresult), 64'h0000000F);
        md_valid = 1'b0; funct = '0;
        {m_hi, m_lo} = res;
        rd("mult 3*5");
        op(F_MTHI, 32'hA5A5A5A5, 32'd0, "mthi");
        op(F_MTLO, 32'h5A5A0001, 32'd0, "mtlo");
        for (int i = 0; i < 20; i++) begin
            op(fl[$urandom_range(0, 7)], pick(), pick(), $sformatf("rand%0d", i));
        end
        op(F_MULT, 32'h12345678, 32'h9, "pre-reset mult");
        issue(F_MULT, 32'h0BADF00D, 32'h0000ABCD);
        repeat (9) @(negedge clk);
        #2 reset = 1'b0;
        #1 chk("midop reset busy", 64'(busy), 64'd0);
        chk("midop reset stall", 64'(stall), 64'd0);
        md_valid = 1'b1; funct = F_MFHI;
        #1 chk("midop reset hi", 64'(mdresult), 64'd0);
        funct = F_MFLO;
        #1 chk("midop reset lo", 64'(mdresult), 64'd0);
        chk("midop reset stall mflo", 64'(stall), 64'd0);
        md_valid = 1'b0; funct = '0;
        m_hi = '0; m_lo = '0;
        @(negedge clk) reset = 1'b1;
        rd("after midop reset");
        op(F_MULT, 32'hFFFFFFFF, 32'h80000000, "mult -1*min");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end
endmodule
